gpio_pulse_gen: RTL and testbench

GPIO_PULSE_GEN -- requirements
Module: gpio_pulse_gen

---
 rtl/gpio_pulse_gen.sv | 84 ++++++++
 tb/tb_gpio_pulse_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pulse_gen.sv
// Per-pin one-shot pulse generator: a trigger starts a pulse of `length` clocks at the
// inverted idle level, with busy while running and a done strobe when it finishes.
module gpio_pulse_lane #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trigger,
    input  logic [CNT_WIDTH-1:0] length,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state;
    logic [CNT_WIDTH-1:0] counter;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A zero length is not a pulse: stay idle and never strobe done.
                    if (trigger && (length != '0)) begin
                        state   <= ACTIVE;
                        counter <= length;
                        busy    <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // Trigger is ignored here; the count of 1 ends the pulse, so no wrap.
                    if (counter == CNT_ONE) begin
                        state   <= IDLE;
                        counter <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        counter <= counter - CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

module gpio_pulse_gen #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     trigger,
    input  logic [WIDTH-1:0]     polarity,
    input  logic [CNT_WIDTH-1:0] length,
    output logic [WIDTH-1:0]     out,
    output logic [WIDTH-1:0]     busy,
    output logic [WIDTH-1:0]     done
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_pulse_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .trigger (trigger[i]),
            .length  (length),
            .busy    (busy[i]),
            .done    (done[i])
        );
    end

    // Polarity is live so idle level changes take effect without waiting for a clock.
    assign out = polarity ^ busy;
endmodule

// File: tb/tb_gpio_pulse_gen.sv
// Directed bench for gpio_pulse_gen: each task drives one scenario and checks
// out/busy/done against hand-derived cycle-by-cycle expectations.
module tb_gpio_pulse_gen;
    localparam int WIDTH     = 16;
    localparam int CNT_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [WIDTH-1:0]     trigger;
    logic [WIDTH-1:0]     polarity;
    logic [CNT_WIDTH-1:0] length;
    logic [WIDTH-1:0]     out;
    logic [WIDTH-1:0]     busy;
    logic [WIDTH-1:0]     done;

    int tests_run = 0;
    int tests_failed = 0;

    gpio_pulse_gen #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .trigger  (trigger),
        .polarity (polarity),
        .length   (length),
        .out      (out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // One edge, then settle 1ns past it so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; trigger = '1; polarity = '0; length = 8'd5;
        tick(); tick();
        tests_run++;
        if (busy !== '0) begin tests_failed++; $display("FAIL reset_busy got %h want %h", busy, 16'h0); end
        tests_run++;
        if (done !== '0) begin tests_failed++; $display("FAIL reset_done got %h want %h", done, 16'h0); end
        tests_run++;
        if (out !== '0) begin tests_failed++; $display("FAIL reset_out got %h want %h", out, 16'h0); end
        trigger = '0; reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        polarity = '0; length = 8'd5; trigger = 16'h0001;
        tick();
        trigger = '0;
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (busy[0] !== 1'b1 || out[0] !== 1'b1 || done[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_active cyc %0d got busy=%b out=%b done=%b want 1 1 0", k, busy[0], out[0], done[0]);
            end
            tick();
        end
        tests_run++;
        if (busy[0] !== 1'b0 || out[0] !== 1'b0 || done[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_end got busy=%b out=%b done=%b want 0 0 1", busy[0], out[0], done[0]);
        end
        tick();
        tests_run++;
        if (done[0] !== 1'b0) begin tests_failed++; $display("FAIL basic_done_clear got %b want 0", done[0]); end
    endtask

    // Trigger held high: 4 busy cycles, 1 idle cycle with done, repeat.
    task automatic test_back_to_back();
        int bad = 0;
        int dones = 0;
        length = 8'd4; trigger = 16'h0008;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (busy[3] !== ((e % 5) != 0) || done[3] !== ((e % 5) == 0)) begin
                bad++;
                $display("FAIL b2b edge %0d got busy=%b done=%b want %b %b", e, busy[3], done[3], (e % 5) != 0, (e % 5) == 0);
            end
            if (done[3] === 1'b1) dones++;
        end
        trigger = '0;
        tests_run++;
        if (bad != 0) tests_failed++;
        tests_run++;
        if (dones != 2) begin tests_failed++; $display("FAIL b2b_done_count got %0d want 2", dones); end
        tick();
        tests_run++;
        if (busy[3] !== 1'b0 || done[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_after got busy=%b done=%b want 0 0", busy[3], done[3]);
        end
    endtask

    task automatic test_zero_length_and_change();
        int bad = 0;
        length = 8'd0; trigger = 16'h0004;
        for (int e = 0; e < 3; e++) begin
            tick();
            if (busy[2] !== 1'b0 || done[2] !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL zero_length got %0d bad cycles want 0", bad); end
        length = 8'd3;
        tick();
        trigger = '0; length = 8'd9;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (busy[2] !== 1'b1) begin tests_failed++; $display("FAIL len_change_active cyc %0d got %b want 1", k, busy[2]); end
            tick();
        end
        tests_run++;
        if (busy[2] !== 1'b0 || done[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL len_change_end got busy=%b done=%b want 0 1", busy[2], done[2]);
        end
        length = 8'd0;
        tick();
    endtask

    task automatic test_polarity();
        logic [3:0] seq;
        polarity = 16'h0002; length = 8'd2;
        #1;
        seq[3] = out[1];
        trigger = 16'h0002;
        tick();
        trigger = '0;
        seq[2] = out[1];
        tick();
        seq[1] = out[1];
        tick();
        seq[0] = out[1];
        tests_run++;
        if (seq !== 4'b1001) begin tests_failed++; $display("FAIL polarity_seq got %b want 1001", seq); end
        tick();
        trigger = 16'h0002;
        tick();
        trigger = '0;
        tests_run++;
        if (out[1] !== 1'b0) begin tests_failed++; $display("FAIL polarity_pre_flip got %b want 0", out[1]); end
        polarity = 16'h0000;
        #1;
        tests_run++;
        if (out[1] !== 1'b1) begin tests_failed++; $display("FAIL polarity_flip_now got %b want 1", out[1]); end
        tick();
        tests_run++;
        if (out[1] !== 1'b1 || busy[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL polarity_flip_hold got out=%b busy=%b want 1 1", out[1], busy[1]);
        end
        tick();
        tests_run++;
        if (out[1] !== 1'b0) begin tests_failed++; $display("FAIL polarity_flip_end got %b want 0", out[1]); end
        tick();
    endtask

    task automatic test_reset_mid_pulse();
        polarity = 16'h0010; length = 8'd8; trigger = 16'h0010;
        tick();
        trigger = '0;
        tick();
        // Reset pulsed between edges must not disturb the running pulse.
        reset = 1'b0;
        #2;
        tests_run++;
        if (busy[4] !== 1'b1) begin tests_failed++; $display("FAIL reset_sync got busy=%b want 1", busy[4]); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tests_run++;
        if (busy[4] !== 1'b0 || done[4] !== 1'b0 || out !== polarity) begin
            tests_failed++;
            $display("FAIL reset_mid got busy=%b done=%b out=%h want 0 0 %h", busy[4], done[4], out, polarity);
        end
        tick();
        tests_run++;
        if (done[4] !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_nodone got %b want 0", done[4]); end
        trigger = 16'h0010;
        tick();
        trigger = '0;
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (busy[4] !== 1'b1 || out[4] !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_refire cyc %0d got busy=%b out=%b want 1 0", k, busy[4], out[4]);
            end
            tick();
        end
        tests_run++;
        if (busy[4] !== 1'b0 || done[4] !== 1'b1 || out[4] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_refire_end got busy=%b done=%b out=%b want 0 1 1", busy[4], done[4], out[4]);
        end
        polarity = '0;
        tick();
    endtask

    task automatic test_max_multi_pin();
        int bad = 0;
        length = 8'd255; trigger = 16'h8001;
        tick();
        trigger = '0;
        for (int k = 0; k < 255; k++) begin
            if (busy !== 16'h8001 || done !== 16'h0000) begin
                if (bad == 0) $display("FAIL max_active cyc %0d got busy=%h done=%h want 8001 0000", k, busy, done);
                bad++;
            end
            tick();
        end
        tests_run++;
        if (bad != 0) tests_failed++;
        tests_run++;
        if (busy !== 16'h0000 || done !== 16'h8001) begin
            tests_failed++;
            $display("FAIL max_end got busy=%h done=%h want 0000 8001", busy, done);
        end
        tick();
        tests_run++;
        if (done !== 16'h0000) begin tests_failed++; $display("FAIL max_done_clear got %h want 0000", done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_length_and_change();
        test_polarity();
        test_reset_mid_pulse();
        test_max_multi_pin();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
